// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared constants, FSM state and DataWidth encodings for dcache
package dcache_pkg;

  localparam int DEF_NUM_SETS   = 8;
  localparam int DEF_LINE_WORDS = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_REFILL = 2'd1;
  localparam state_t ST_WRITE  = 2'd2;

  localparam logic [2:0] DW_B  = 3'b000;
  localparam logic [2:0] DW_H  = 3'b001;
  localparam logic [2:0] DW_W  = 3'b010;
  localparam logic [2:0] DW_BU = 3'b100;
  localparam logic [2:0] DW_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  // Unused funct3 codes fall through to a full-word access.
  function automatic acc_size_e dw_size(input logic [2:0] dw);
    case (dw)
      DW_B, DW_BU: return SZ_BYTE;
      DW_H, DW_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

  function automatic logic dw_signed(input logic [2:0] dw);
    return (dw == DW_B) || (dw == DW_H);
  endfunction

endpackage

// File: rtl/dcache_if.sv
// rtl/dcache_if.sv - CPU request/response and backing-memory bus bundle for dcache
interface dcache_if;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [2:0]  DataWidth;
  logic [31:0] ReadData;
  logic        Stall;

  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [31:0] BusWData;
  logic [3:0]  BusStrb;
  logic        BusAck;
  logic [31:0] BusRData;

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData, DataWidth, BusAck, BusRData,
    output ReadData, Stall, BusReq, BusWe, BusAddr, BusWData, BusStrb
  );

  modport master (
    output MemRead, MemWrite, Addr, WriteData, DataWidth, BusAck, BusRData,
    input  ReadData, Stall, BusReq, BusWe, BusAddr, BusWData, BusStrb
  );

endinterface

// File: rtl/dcache_lsu_align.sv
// rtl/dcache_lsu_align.sv - store lane/strobe generation and load byte/half extraction
module lsu_align
  import dcache_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [2:0]  width_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  strb_o,
  output logic [31:0] lane_data_o,
  output logic [31:0] rdata_o
);

  acc_size_e   size;
  logic        sext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Misaligned halves drop Addr[0]; words ignore the offset entirely.
  always_comb begin
    size        = dw_size(width_i);
    sext        = dw_signed(width_i);
    byte_sel    = rword_i[{offset_i, 3'b000} +: 8];
    half_sel    = offset_i[1] ? rword_i[31:16] : rword_i[15:0];
    strb_o      = 4'b1111;
    lane_data_o = wdata_i;
    rdata_o     = rword_i;
    case (size)
      SZ_BYTE: begin
        strb_o      = 4'b0001 << offset_i;
        lane_data_o = {4{wdata_i[7:0]}};
        rdata_o     = {{24{sext & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        strb_o      = offset_i[1] ? 4'b1100 : 4'b0011;
        lane_data_o = {2{wdata_i[15:0]}};
        rdata_o     = {{16{sext & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-through, no-write-allocate data cache
// with zero-latency load hits and a single-beat backing-memory bus.
module dcache
  import dcache_pkg::*;
#(
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input logic     clk,
  input logic     rst,
  dcache_if.slave io
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 30 - WORD_W - SET_W;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [31:0]         data_q [NUM_SETS][LINE_WORDS];

  logic [SET_W-1:0]  set_idx;
  logic [WORD_W-1:0] word_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              is_store;
  logic              is_load;
  logic [31:0]       line_word;
  logic [3:0]        strb;
  logic [31:0]       lane_data;
  logic [31:0]       load_data;

  logic        refill_we;
  logic        refill_last;
  logic        store_we;
  logic        stall;
  logic [31:0] rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strb;

  assign set_idx   = io.Addr[2+WORD_W +: SET_W];
  assign word_idx  = io.Addr[2 +: WORD_W];
  assign req_tag   = io.Addr[31 -: TAG_W];
  assign hit       = valid_q[set_idx] && (tag_q[set_idx] == req_tag);
  assign is_store  = io.MemWrite;
  assign is_load   = io.MemRead && !io.MemWrite;
  assign line_word = data_q[set_idx][word_idx];

  lsu_align u_align (
    .offset_i    (io.Addr[1:0]),
    .width_i     (io.DataWidth),
    .wdata_i     (io.WriteData),
    .rword_i     (line_word),
    .strb_o      (strb),
    .lane_data_o (lane_data),
    .rdata_o     (load_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    refill_we   = 1'b0;
    refill_last = 1'b0;
    store_we    = 1'b0;
    stall       = 1'b0;
    rdata       = '0;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_wdata   = '0;
    bus_strb    = '0;
    case (state_q)
      ST_IDLE: begin
        if (is_store) begin
          stall   = 1'b1;
          state_d = ST_WRITE;
        end else if (is_load) begin
          if (hit) begin
            rdata = load_data;
          end else begin
            // The victim goes invalid up front so an aborted refill never looks valid.
            stall            = 1'b1;
            state_d          = ST_REFILL;
            cnt_d            = '0;
            valid_d[set_idx] = 1'b0;
          end
        end
      end
      ST_REFILL: begin
        stall    = 1'b1;
        bus_req  = 1'b1;
        bus_addr = {io.Addr[31:2+WORD_W], cnt_q, 2'b00};
        bus_strb = 4'b1111;
        if (io.BusAck) begin
          refill_we = 1'b1;
          cnt_d     = cnt_q + WORD_W'(1);
          if (cnt_q == WORD_W'(LINE_WORDS - 1)) begin
            refill_last      = 1'b1;
            valid_d[set_idx] = 1'b1;
            state_d          = ST_IDLE;
          end
        end
      end
      ST_WRITE: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = {io.Addr[31:2], 2'b00};
        bus_strb  = strb;
        bus_wdata = lane_data;
        if (io.BusAck) begin
          store_we = hit;
          state_d  = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data storage carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (refill_we) begin
      data_q[set_idx][cnt_q] <= io.BusRData;
    end
    if (refill_last) begin
      tag_q[set_idx] <= req_tag;
    end
    if (store_we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) begin
          data_q[set_idx][word_idx][8*b +: 8] <= lane_data[8*b +: 8];
        end
      end
    end
  end

  assign io.Stall    = !rst && stall;
  assign io.ReadData = rst ? '0 : rdata;
  assign io.BusReq   = !rst && bus_req;
  assign io.BusWe    = !rst && bus_we;
  assign io.BusAddr  = rst ? '0 : bus_addr;
  assign io.BusWData = rst ? '0 : bus_wdata;
  assign io.BusStrb  = rst ? '0 : bus_strb;

endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - scoreboard bench for dcache: directed scenarios plus random
// loads/stores checked against a behavioural cache and memory model.
module tb_dcache;

  localparam int NS         = 8;
  localparam int LW         = 4;
  localparam int LINE_BYTES = 4 * LW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_if io ();

  dcache #(.NUM_SETS(NS), .LINE_WORDS(LW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  typedef struct {
    logic [31:0] data;
    bit          zero_lat;
  } rd_exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_exp_t;

  rd_exp_t  rd_q[$];
  bus_exp_t bus_q[$];

  logic [31:0] ref_mem [int unsigned];
  logic [31:0] bus_mem [int unsigned];
  bit          m_valid [NS];
  int unsigned m_tag   [NS];

  int n_vec       = 0;
  int n_bad       = 0;
  int completions = 0;
  int beats_seen  = 0;
  int stall_cyc   = 0;
  int fixed_delay = -1;
  int wait_left   = 0;
  bit req_on      = 1'b0;
  bit abort       = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] bus_word(input int unsigned wa);
    return bus_mem.exists(wa) ? bus_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    logic [31:0] mask;
    mask = 0;
    for (int i = 0; i < 4; i++) if (strb[i]) mask = mask | (32'hFF << (8 * i));
    return (old & ~mask) | (nw & mask);
  endfunction

  function automatic logic [3:0] exp_strb(input int unsigned off, input logic [2:0] dw);
    case (dw)
      3'b000, 3'b100: return 4'(1 << off);
      3'b001, 3'b101: return 4'(3 << (2 * (off / 2)));
      default:        return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [2:0] dw);
    case (dw)
      3'b000, 3'b100: return (wd & 32'hFF) * 32'h01010101;
      3'b001, 3'b101: return (wd & 32'hFFFF) * 32'h00010001;
      default:        return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input int unsigned off, input logic [2:0] dw);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (dw)
      3'b000:  return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // Model step: predicts bus beats and the response, then drives one request.
  task automatic push_request(input bit mr, input bit mw, input logic [31:0] a, input logic [2:0] dw,
                              input logic [31:0] wd, input bit fx, input logic [31:0] fexp);
    rd_exp_t     e;
    bus_exp_t    b;
    int unsigned set_n;
    int unsigned tag_n;
    int unsigned base;
    set_n = (a / LINE_BYTES) % NS;
    tag_n = a / (LINE_BYTES * NS);
    base  = a - (a % LINE_BYTES);
    e.data     = 0;
    e.zero_lat = 0;
    if (mw) begin
      b.we    = 1;
      b.addr  = a - (a % 4);
      b.strb  = exp_strb(a % 4, dw);
      b.wdata = exp_wdata(wd, dw);
      bus_q.push_back(b);
      ref_mem[a / 4] = merge(ref_word(a / 4), b.wdata, b.strb);
    end else begin
      if (m_valid[set_n] && m_tag[set_n] == tag_n) begin
        e.zero_lat = 1;
      end else begin
        for (int i = 0; i < LW; i++) begin
          b.we    = 0;
          b.addr  = base + 4 * i;
          b.strb  = 4'hF;
          b.wdata = 0;
          bus_q.push_back(b);
        end
        m_valid[set_n] = 1;
        m_tag[set_n]   = tag_n;
      end
      e.data = exp_load(ref_word(a / 4), a % 4, dw);
    end
    if (fx) e.data = fexp;
    rd_q.push_back(e);
    io.MemRead   = mr;
    io.MemWrite  = mw;
    io.Addr      = a;
    io.DataWidth = dw;
    io.WriteData = wd;
    req_on       = 1;
  endtask

  task automatic issue(input bit mr, input bit mw, input logic [31:0] a, input logic [2:0] dw,
                       input logic [31:0] wd, input bit fx, input logic [31:0] fexp);
    int target;
    bit done;
    if (abort) return;
    target = completions + 1;
    push_request(mr, mw, a, dw, wd, fx, fexp);
    done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk);
      if (completions >= target) done = 1;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL request_timeout: addr %h got no completion, required one within 400 cycles", a);
      abort = 1;
    end
    #1;
    io.MemRead  = 0;
    io.MemWrite = 0;
    req_on      = 0;
  endtask

  // Backing memory: random (or fixed) ack delay, checks each beat against the model.
  initial begin
    bus_exp_t b;
    io.BusAck   = 0;
    io.BusRData = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        io.BusAck = 0;
        wait_left = 0;
      end else if (io.BusAck) begin
        io.BusAck = 0;
        wait_left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      end else if (io.BusReq) begin
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          if (bus_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL bus_unexpected: beat at %h we %0d, required no beat", io.BusAddr, io.BusWe);
          end else begin
            b = bus_q.pop_front();
            check("bus_we", 32'(io.BusWe), 32'(b.we));
            check("bus_addr", io.BusAddr, b.addr);
            check("bus_strb", 32'(io.BusStrb), 32'(b.strb));
            if (b.we) check("bus_wdata", io.BusWData, b.wdata);
          end
          if (io.BusWe) bus_mem[io.BusAddr / 4] = merge(bus_word(io.BusAddr / 4), io.BusWData, io.BusStrb);
          else          io.BusRData = bus_word(io.BusAddr / 4);
          beats_seen++;
          io.BusAck = 1;
        end
      end
    end
  end

  // Response monitor: a request completes on the first cycle Stall is low.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (req_on) begin
          if (io.Stall) begin
            stall_cyc++;
            check("rdata_while_stalled", io.ReadData, 0);
          end else begin
            if (rd_q.size() == 0) begin
              n_vec++;
              n_bad++;
              $display("FAIL unexpected_completion: ReadData %h, required no completion", io.ReadData);
            end else begin
              e = rd_q.pop_front();
              check("read_data", io.ReadData, e.data);
              check("zero_latency", 32'(stall_cyc == 0), 32'(e.zero_lat));
              check("bus_beats_left", bus_q.size(), 0);
            end
            stall_cyc = 0;
            completions++;
          end
        end else begin
          check("idle_ctrl", {28'd0, io.Stall, io.BusReq, io.BusWe, |io.BusStrb}, 0);
          check("idle_rdata", io.ReadData, 0);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  dw;
    int          op;
    int          b0;
    bit          hit2;
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
    end
    rst          = 1;
    io.MemRead   = 1;
    io.MemWrite  = 0;
    io.Addr      = 32'h100;
    io.DataWidth = 3'b010;
    io.WriteData = 0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {26'd0, io.Stall, io.BusReq, io.BusWe, io.BusStrb[2:0]}, 0);
    check("reset_strb_hi", 32'(io.BusStrb[3]), 0);
    check("reset_addr", io.BusAddr, 0);
    check("reset_wdata", io.BusWData, 0);
    check("reset_rdata", io.ReadData, 0);
    io.MemRead = 0;
    rst = 0;
    @(posedge clk);
    #1;

    fixed_delay = 2;
    foreach (ref_mem[k]) ref_mem.delete(k);
    ref_mem[32'h100 / 4] = 32'h0000_0011;
    ref_mem[32'h104 / 4] = 32'h80FF_0022;
    ref_mem[32'h108 / 4] = 32'h0000_0033;
    ref_mem[32'h10C / 4] = 32'h0000_0044;
    bus_mem = ref_mem;

    issue(1, 0, 32'h100, 3'b010, 0, 1, 32'h0000_0011);
    issue(1, 0, 32'h100, 3'b010, 0, 1, 32'h0000_0011);
    issue(1, 0, 32'h107, 3'b000, 0, 1, 32'hFFFF_FF80);
    issue(1, 0, 32'h107, 3'b100, 0, 1, 32'h0000_0080);
    issue(1, 0, 32'h106, 3'b001, 0, 1, 32'hFFFF_80FF);
    issue(1, 0, 32'h107, 3'b001, 0, 1, 32'hFFFF_80FF);
    issue(1, 0, 32'h103, 3'b011, 0, 1, 32'h0000_0011);
    issue(0, 1, 32'h105, 3'b000, 32'h1234_56AB, 0, 0);
    issue(1, 0, 32'h104, 3'b010, 0, 1, 32'h80FF_AB22);
    issue(0, 1, 32'h200, 3'b010, 32'hCAFE_F00D, 0, 0);
    issue(1, 0, 32'h200, 3'b010, 0, 1, 32'hCAFE_F00D);
    issue(1, 1, 32'h100, 3'b010, 32'h0BAD_BEEF, 0, 0);
    issue(1, 0, 32'h100, 3'b010, 0, 1, 32'h0BAD_BEEF);

    // Reset lands right after the second refill beat of 0x300 is consumed.
    if (!abort) begin
      b0 = beats_seen;
      push_request(1, 0, 32'h300, 3'b010, 0, 0, 0);
      hit2 = 0;
      for (int c = 0; c < 100 && !hit2; c++) begin
        @(posedge clk);
        if (beats_seen >= b0 + 2) hit2 = 1;
      end
      if (!hit2) begin
        n_vec++;
        n_bad++;
        $display("FAIL refill_beats_timeout: saw %0d beats, required 2", beats_seen - b0);
      end
      #1;
      rst        = 1;
      io.MemRead = 0;
      req_on     = 0;
      rd_q.delete();
      bus_q.delete();
      stall_cyc  = 0;
      m_valid[(32'h300 / LINE_BYTES) % NS] = 0;
      #1;
      check("abort_busreq", 32'(io.BusReq), 0);
      check("abort_stall", 32'(io.Stall), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      @(posedge clk);
      #1;
      issue(1, 0, 32'h300, 3'b010, 0, 0, 0);
      issue(1, 0, 32'h30C, 3'b101, 0, 0, 0);
    end

    fixed_delay = -1;
    for (int n = 0; n < 400 && !abort; n++) begin
      a  = $urandom_range(0, 511);
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      dw = 3'($urandom_range(0, 7));
      op = $urandom_range(0, 9);
      if (op < 6)      issue(1, 0, a, dw, $urandom, 0, 0);
      else if (op < 9) issue(0, 1, a, dw, $urandom, 0, 0);
      else             issue(1, 1, a, dw, $urandom, 0, 0);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
